link_scheduler: RTL and testbench
=================================

# link_scheduler

Sequences one command/reply exchange on the reader link. It starts the TX command path, then blanks the RX path during the T1 turnaround and arms it, clearing the preamble/bits/CRC chain. It then bounds the wait for a tag preamble and for end of frame, judges the reply by CRC16, and enforces the T2 gap before the next command. It retries on failure up to a set limit.

## Interface
Parameters:
- T1_MIN, 20: blanking cycles after TX end; RX ignored.
- T1_MAX, 200: cycles in LISTEN before no-reply timeout.
- RX_MAX, 4000: cycles in RECV before frame timeout.
- T2_MIN, 40: gap cycles after a reply or failure.
- RETRIES, 2: extra attempts after the first (0 = single shot).
- CNT_W, 16: state-timer width; must hold max(T1_MIN, T1_MAX, RX_MAX, T2_MIN).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous active-high reset.
- cmd_req, in, 1: level; request an exchange.
- abort, in, 1: pulse; abandon the exchange.
- tx_done, in, 1: pulse from the TX path at end of the command.
- rx_sof, in, 1: preamble detected.
- rx_eof, in, 1: postamble detected.
- crc_ok, in, 1: CRC16 check result, valid on the rx_eof cycle.
- tx_start, out, 1: one-cycle pulse; launch command.
- rx_en, out, 1: RX path enable.
- rx_clr, out, 1: one-cycle pulse; reset the RX chain and CRC.
- reply_ok, out, 1: one-cycle pulse; good reply.
- reply_fail, out, 1: one-cycle pulse; exchange failed, retries exhausted.
- fail_code, out, 2: 00 none, 01 no reply, 10 frame timeout, 11 CRC error.
- attempt, out, 2: current attempt index, starting at 0.
- busy, out, 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, TX, BLANK, LISTEN, RECV, GAP. All outputs are registered.
- On every state entry, a timer loads 0 and then counts up by 1 each cycle.
- IDLE:
  - On cmd_req=1, go to TX.
  - attempt and fail_code are cleared to 0.
- TX:
  - tx_start=1 on the first TX cycle only.
  - Wait for tx_done, then go to BLANK.
  - There is no timeout in TX.
- BLANK:
  - rx_en=0, and rx_sof and rx_eof are ignored.
  - When the timer reaches T1_MIN-1, go to LISTEN.
- LISTEN:
  - rx_en=1, and rx_clr=1 on the first LISTEN cycle.
  - On rx_sof, go to RECV.
  - When the timer reaches T1_MAX-1 without rx_sof, record fail_code=01 and fail.
- RECV:
  - rx_en=1.
  - On rx_eof with crc_ok=1, pulse reply_ok and go to GAP.
  - On rx_eof with crc_ok=0, record fail_code=11 and fail.
  - When the timer reaches RX_MAX-1, record fail_code=10 and fail.
- Fail handling:
  - If attempt<RETRIES, go to GAP with the retry flag set.
  - Otherwise pulse reply_fail, which coincides with the fail_code update, and go to GAP.
- GAP:
  - rx_en=0.
  - When the timer reaches T2_MIN-1:
    - If the retry flag is set, increment attempt and go to TX; tx_start fires again.
    - Otherwise go to IDLE.
- abort:
  - From any state, go to IDLE on the next cycle, with rx_en=0.
  - No reply_ok or reply_fail pulse is issued.
  - fail_code and attempt hold their values until the next IDLE cycle.
- cmd_req deasserting mid-exchange has no effect. If cmd_req is still high on return to IDLE, the next exchange starts.

## Timing
- Reset values of all outputs are 0, and the state is IDLE.
- cmd_req is sampled high in IDLE at cycle n; tx_start=1 and busy=1 at cycle n+1.
- tx_done at cycle n puts BLANK at n+1 and LISTEN with rx_clr at n+1+T1_MIN.
- rx_eof at cycle n puts reply_ok or the fail decision at n+1, and IDLE at n+1+T2_MIN.
- Simultaneous events:
  - rx_sof in the timeout cycle of LISTEN: rx_sof wins.
  - rx_eof in the timeout cycle of RECV: rx_eof wins.
  - abort together with any other event: abort wins.
- rx_sof arriving while in RECV is ignored; no restart.
- rx_eof arriving while in LISTEN is ignored.
- Minimum exchange length (ok case) is 1 + T1_MIN + 1 + 1 + T2_MIN cycles.
- Asynchronous reset asserted mid-exchange clears everything immediately. No pulses are emitted after release.

## Structure
- link_pkg holds:
  - the state enumeration;
  - the fail-code constants FAIL_NONE, FAIL_NOREPLY, FAIL_FRAME, FAIL_CRC.
- One sub-module, state_timer: a CNT_W-bit up-counter with clear-on-entry and a compare output. It is instanced once and shared by all states.
- Parameter checks cover:
  - T1_MIN ≥ 1;
  - T2_MIN ≥ 1;
  - T1_MAX ≥ 1;
  - RX_MAX < 2^CNT_W.

## Test plan
- Good reply: cmd_req, then tx_done, then rx_sof 30 cycles into LISTEN, then rx_eof with crc_ok=1. Expect exactly one tx_start, one rx_clr and one reply_ok, fail_code=00, and busy low T2_MIN+1 cycles after rx_eof.
- No reply with RETRIES=2: no rx_sof. Expect 3 tx_start pulses and attempt stepping 0→1→2, then one reply_fail with fail_code=01.
- CRC error then success: attempt 0 ends with crc_ok=0 and attempt 1 with crc_ok=1. Expect reply_ok, no reply_fail, and attempt=1.
- Blanking and ties:
  - rx_sof during BLANK: ignored, and a timeout follows.
  - rx_sof in the last LISTEN cycle: enters RECV.
  - rx_eof in the last RECV cycle: judged by crc_ok, not a timeout.
- abort in RECV, and a separate case of async rst in LISTEN: expect IDLE next cycle (or immediately for rst), rx_en=0, and no reply pulses.
- Frame timeout with RX_MAX=100 and RETRIES=0: rx_sof with no rx_eof gives reply_fail exactly 100 cycles after RECV entry, with fail_code=10.

Source files
------------

// File: rtl/link_pkg.sv
// Shared state encoding and fail-code constants for the reader-link scheduler.
package link_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTx,
        StBlank,
        StListen,
        StRecv,
        StGap
    } state_e;

    localparam logic [1:0] FAIL_NONE    = 2'b00;
    localparam logic [1:0] FAIL_NOREPLY = 2'b01;
    localparam logic [1:0] FAIL_FRAME   = 2'b10;
    localparam logic [1:0] FAIL_CRC     = 2'b11;

endpackage

// File: rtl/link_scheduler_if.sv
// Handshake bundle between the exchange scheduler and the TX/RX link paths.
interface link_scheduler_if;

    logic       cmd_req;
    logic       abort;
    logic       tx_done;
    logic       rx_sof;
    logic       rx_eof;
    logic       crc_ok;
    logic       tx_start;
    logic       rx_en;
    logic       rx_clr;
    logic       reply_ok;
    logic       reply_fail;
    logic [1:0] fail_code;
    logic [1:0] attempt;
    logic       busy;

    modport master (
        input  cmd_req, abort, tx_done, rx_sof, rx_eof, crc_ok,
        output tx_start, rx_en, rx_clr, reply_ok, reply_fail, fail_code, attempt, busy
    );

    modport slave (
        output cmd_req, abort, tx_done, rx_sof, rx_eof, crc_ok,
        input  tx_start, rx_en, rx_clr, reply_ok, reply_fail, fail_code, attempt, busy
    );

endinterface

// File: rtl/state_timer.sv
// Shared state timer: restarts at 0 on every state entry and flags a programmable count.
module state_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] cmp_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = clr_i ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit_o = (count_q == cmp_i);

endmodule

// File: rtl/link_scheduler.sv
// Sequences one command/reply exchange: TX launch, RX blanking, bounded listen and receive,
// CRC judgement, post-exchange gap and bounded retries.
module link_scheduler
    import link_pkg::*;
#(
    parameter int unsigned T1_MIN  = 20,
    parameter int unsigned T1_MAX  = 200,
    parameter int unsigned RX_MAX  = 4000,
    parameter int unsigned T2_MIN  = 40,
    parameter int unsigned RETRIES = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    link_scheduler_if.master lnk
);

    localparam logic [CNT_W-1:0] T1_MIN_CMP = CNT_W'(T1_MIN - 1);
    localparam logic [CNT_W-1:0] T1_MAX_CMP = CNT_W'(T1_MAX - 1);
    localparam logic [CNT_W-1:0] RX_MAX_CMP = CNT_W'(RX_MAX - 1);
    localparam logic [CNT_W-1:0] T2_MIN_CMP = CNT_W'(T2_MIN - 1);

    if (T1_MIN < 1) begin : gen_chk_t1_min
        $error("T1_MIN must be at least 1");
    end
    if (T2_MIN < 1) begin : gen_chk_t2_min
        $error("T2_MIN must be at least 1");
    end
    if (T1_MAX < 1) begin : gen_chk_t1_max
        $error("T1_MAX must be at least 1");
    end
    if (CNT_W < 32 && RX_MAX >= (32'd1 << CNT_W)) begin : gen_chk_rx_max
        $error("RX_MAX does not fit in CNT_W bits");
    end
    if (RETRIES > 3) begin : gen_chk_retries
        $error("RETRIES must fit the 2-bit attempt counter");
    end

    state_e           state_q, state_d;
    logic [1:0]       attempt_q, attempt_d;
    logic [1:0]       fail_code_q, fail_code_d;
    logic             retry_q, retry_d;
    logic             tx_start_q, tx_start_d;
    logic             rx_en_q, rx_en_d;
    logic             rx_clr_q, rx_clr_d;
    logic             reply_ok_q, reply_ok_d;
    logic             reply_fail_q, reply_fail_d;
    logic             busy_q, busy_d;
    logic             fail_now;
    logic [1:0]       fail_kind;
    logic             timer_hit;
    logic [CNT_W-1:0] timer_cmp;

    always_comb begin
        unique case (state_q)
            StBlank:  timer_cmp = T1_MIN_CMP;
            StListen: timer_cmp = T1_MAX_CMP;
            StRecv:   timer_cmp = RX_MAX_CMP;
            StGap:    timer_cmp = T2_MIN_CMP;
            default:  timer_cmp = '1;
        endcase
    end

    state_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_d != state_q),
        .cmp_i (timer_cmp),
        .hit_o (timer_hit)
    );

    always_comb begin
        state_d      = state_q;
        attempt_d    = attempt_q;
        fail_code_d  = fail_code_q;
        retry_d      = retry_q;
        tx_start_d   = 1'b0;
        rx_clr_d     = 1'b0;
        reply_ok_d   = 1'b0;
        reply_fail_d = 1'b0;
        fail_now     = 1'b0;
        fail_kind    = FAIL_NONE;

        unique case (state_q)
            StIdle: begin
                attempt_d   = 2'd0;
                fail_code_d = FAIL_NONE;
                retry_d     = 1'b0;
                if (lnk.cmd_req) begin
                    state_d    = StTx;
                    tx_start_d = 1'b1;
                end
            end
            StTx: begin
                if (lnk.tx_done) state_d = StBlank;
            end
            StBlank: begin
                if (timer_hit) begin
                    state_d  = StListen;
                    rx_clr_d = 1'b1;
                end
            end
            StListen: begin
                // A preamble on the timeout cycle still counts as a reply.
                if (lnk.rx_sof) begin
                    state_d = StRecv;
                end else if (timer_hit) begin
                    fail_now  = 1'b1;
                    fail_kind = FAIL_NOREPLY;
                end
            end
            StRecv: begin
                if (lnk.rx_eof) begin
                    if (lnk.crc_ok) begin
                        state_d    = StGap;
                        reply_ok_d = 1'b1;
                    end else begin
                        fail_now  = 1'b1;
                        fail_kind = FAIL_CRC;
                    end
                end else if (timer_hit) begin
                    fail_now  = 1'b1;
                    fail_kind = FAIL_FRAME;
                end
            end
            StGap: begin
                if (timer_hit) begin
                    if (retry_q) begin
                        state_d    = StTx;
                        attempt_d  = attempt_q + 2'd1;
                        retry_d    = 1'b0;
                        tx_start_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (fail_now) begin
            state_d     = StGap;
            fail_code_d = fail_kind;
            if ({30'd0, attempt_q} < RETRIES) begin
                retry_d = 1'b1;
            end else begin
                reply_fail_d = 1'b1;
            end
        end

        // Abort overrides everything but leaves attempt/fail_code for IDLE to clear.
        if (lnk.abort) begin
            state_d      = StIdle;
            attempt_d    = attempt_q;
            fail_code_d  = fail_code_q;
            retry_d      = 1'b0;
            tx_start_d   = 1'b0;
            rx_clr_d     = 1'b0;
            reply_ok_d   = 1'b0;
            reply_fail_d = 1'b0;
        end

        rx_en_d = (state_d == StListen) || (state_d == StRecv);
        busy_d  = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            attempt_q    <= 2'd0;
            fail_code_q  <= FAIL_NONE;
            retry_q      <= 1'b0;
            tx_start_q   <= 1'b0;
            rx_en_q      <= 1'b0;
            rx_clr_q     <= 1'b0;
            reply_ok_q   <= 1'b0;
            reply_fail_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            attempt_q    <= attempt_d;
            fail_code_q  <= fail_code_d;
            retry_q      <= retry_d;
            tx_start_q   <= tx_start_d;
            rx_en_q      <= rx_en_d;
            rx_clr_q     <= rx_clr_d;
            reply_ok_q   <= reply_ok_d;
            reply_fail_q <= reply_fail_d;
            busy_q       <= busy_d;
        end
    end

    assign lnk.tx_start   = tx_start_q;
    assign lnk.rx_en      = rx_en_q;
    assign lnk.rx_clr     = rx_clr_q;
    assign lnk.reply_ok   = reply_ok_q;
    assign lnk.reply_fail = reply_fail_q;
    assign lnk.fail_code  = fail_code_q;
    assign lnk.attempt    = attempt_q;
    assign lnk.busy       = busy_q;

endmodule

// File: tb/tb_link_scheduler.sv
// Randomized bench for link_scheduler: exchanges are planned from the timing rules, expected
// output events are queued per kind, and a negedge monitor matches every observed pulse/edge.
module tb_link_scheduler;

    localparam int unsigned T1_MIN  = 20;
    localparam int unsigned T1_MAX  = 200;
    localparam int unsigned RX_MAX  = 100;
    localparam int unsigned T2_MIN  = 40;
    localparam int unsigned RETRIES = 2;
    localparam int unsigned CNT_W   = 16;

    localparam int K_TX = 0, K_CLR = 1, K_OK = 2, K_FAIL = 3, K_BSY = 4, K_RON = 5, K_ROFF = 6;
    localparam int O_OK = 0, O_NOREPLY = 1, O_CRC = 2, O_FRAME = 3, O_RAND = 4;
    localparam int P_TXDONE = 0, P_SOF = 1, P_EOF_OK = 2, P_EOF_BAD = 3, P_ABORT = 4;
    localparam int P_ABORT_EOF = 5;

    typedef struct {
        int cyc;
        int att;
        int code;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_rx_en = 1'b0;
    logic prev_busy = 1'b0;
    ev_t  q[7][$];

    link_scheduler_if bif ();

    link_scheduler #(
        .T1_MIN  (T1_MIN),
        .T1_MAX  (T1_MAX),
        .RX_MAX  (RX_MAX),
        .T2_MIN  (T2_MIN),
        .RETRIES (RETRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lnk (bif)
    );

    always #5 clk = ~clk;

    function automatic void push(input int k, input int c, input int a, input int code);
        ev_t e;
        e.cyc  = c;
        e.att  = a;
        e.code = code;
        q[k].push_back(e);
    endfunction

    task automatic mon_kind(input int k, input string nm, input bit seen);
        ev_t e;
        while (q[k].size() != 0) begin
            e = q[k][0];
            if (e.cyc >= cyc) break;
            checks++;
            failures++;
            $display("FAIL %s missed: got no pulse, required at cycle %0d", nm, e.cyc);
            void'(q[k].pop_front());
        end
        if (seen) begin
            checks++;
            if (q[k].size() == 0) begin
                failures++;
                $display("FAIL %s unexpected: got pulse at cycle %0d, required none", nm, cyc);
            end else begin
                e = q[k].pop_front();
                if (e.cyc != cyc || (e.att >= 0 && int'(bif.attempt) != e.att) ||
                    (e.code >= 0 && int'(bif.fail_code) != e.code)) begin
                    failures++;
                    $display("FAIL %s: got cycle=%0d attempt=%0d code=%0d, required cycle=%0d attempt=%0d code=%0d",
                             nm, cyc, bif.attempt, bif.fail_code, e.cyc, e.att, e.code);
                end
            end
        end
    endtask

    // Monitor: one sample per cycle, well away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            mon_kind(K_TX, "tx_start", bif.tx_start);
            mon_kind(K_CLR, "rx_clr", bif.rx_clr);
            mon_kind(K_OK, "reply_ok", bif.reply_ok);
            mon_kind(K_FAIL, "reply_fail", bif.reply_fail);
            mon_kind(K_BSY, "busy_fall", prev_busy && !bif.busy);
            mon_kind(K_RON, "rx_en_rise", bif.rx_en && !prev_rx_en);
            mon_kind(K_ROFF, "rx_en_fall", prev_rx_en && !bif.rx_en);
        end
        prev_busy  = bif.busy;
        prev_rx_en = bif.rx_en;
    end

    task automatic check_val(input string nm, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", nm, got, req);
        end
    endtask

    task automatic goto_cyc(input int t);
        while (cyc < t) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int t, input int kind);
        goto_cyc(t);
        case (kind)
            P_TXDONE:  bif.tx_done = 1'b1;
            P_SOF:     bif.rx_sof = 1'b1;
            P_EOF_OK:  begin bif.rx_eof = 1'b1; bif.crc_ok = 1'b1; end
            P_EOF_BAD: bif.rx_eof = 1'b1;
            P_ABORT:   bif.abort = 1'b1;
            default:   begin bif.abort = 1'b1; bif.rx_eof = 1'b1; bif.crc_ok = 1'b1; end
        endcase
        goto_cyc(t + 1);
        bif.tx_done = 1'b0;
        bif.rx_sof  = 1'b0;
        bif.rx_eof  = 1'b0;
        bif.crc_ok  = 1'b0;
        bif.abort   = 1'b0;
    endtask

    // One exchange; outcomes per attempt, k_fix/j_fix pin the sof/eof offsets (-1 = random).
    task automatic exchange(input int o0, input int o1, input int o2, input bit do_abort,
                            input int k_fix, input int j_fix, input bit noise);
        int  outs[3];
        int  c, s, d, L, R, E, k, j, o, ja, ex_end;
        bit  fin, ab;
        outs   = '{o0, o1, o2};
        c      = cyc;
        s      = c + 1;
        fin    = 1'b0;
        ex_end = 0;
        push(K_TX, s, 0, -1);
        bif.cmd_req = 1'b1;
        goto_cyc(c + $urandom_range(1, 3));
        bif.cmd_req = 1'b0;
        for (int a = 0; a <= int'(RETRIES) && !fin; a++) begin
            o = outs[a];
            if (o == O_RAND) o = $urandom_range(0, 3);
            ab = do_abort && (a == 0) && (o == O_OK || o == O_CRC);
            d  = s + $urandom_range(3, 8);
            L  = d + 1 + T1_MIN;
            k  = T1_MAX;
            j  = RX_MAX;
            R  = 0;
            ja = 0;
            if (o != O_NOREPLY) begin
                k = (k_fix >= 0) ? k_fix :
                    ($urandom_range(0, 3) == 0 ? T1_MAX - 1 : $urandom_range(0, 60));
                R = L + k + 1;
                if (o != O_FRAME)
                    j = (j_fix >= 0) ? j_fix :
                        ($urandom_range(0, 3) == 0 ? RX_MAX - 1 : $urandom_range(0, 40));
            end
            if (o == O_NOREPLY) E = L + T1_MAX;
            else if (o == O_FRAME) E = R + RX_MAX;
            else E = R + j + 1;
            push(K_CLR, L, -1, -1);
            push(K_RON, L, -1, -1);
            if (ab) begin
                ja = $urandom_range(0, j);
                E  = R + ja + 1;
                push(K_ROFF, E, -1, -1);
                push(K_BSY, E, -1, -1);
                fin    = 1'b1;
                ex_end = E;
            end else begin
                push(K_ROFF, E, -1, -1);
                if (o == O_OK) begin
                    push(K_OK, E, a, (a == 0) ? 0 : -1);
                    push(K_BSY, E + T2_MIN, -1, -1);
                    fin    = 1'b1;
                    ex_end = E + T2_MIN;
                end else if (a < int'(RETRIES)) begin
                    s = E + T2_MIN;
                    push(K_TX, s, a + 1, -1);
                end else begin
                    push(K_FAIL, E, a, (o == O_NOREPLY) ? 1 : (o == O_FRAME) ? 2 : 3);
                    push(K_BSY, E + T2_MIN, -1, -1);
                    fin    = 1'b1;
                    ex_end = E + T2_MIN;
                end
            end
            pulse(d, P_TXDONE);
            if (noise) pulse(d + 1 + $urandom_range(0, T1_MIN - 1), P_SOF);
            if (noise && k > 0) pulse(L + $urandom_range(0, k - 1), P_EOF_BAD);
            if (o != O_NOREPLY) begin
                pulse(L + k, P_SOF);
                if (ab) begin
                    if (noise && ja > 0) pulse(R + $urandom_range(0, ja - 1), P_SOF);
                    pulse(R + ja, (ja == j) ? P_ABORT_EOF : P_ABORT);
                end else begin
                    if (noise && j > 0) pulse(R + $urandom_range(0, j - 1), P_SOF);
                    if (o != O_FRAME) pulse(R + j, (o == O_OK) ? P_EOF_OK : P_EOF_BAD);
                end
            end
            goto_cyc(E);
        end
        goto_cyc(ex_end + $urandom_range(0, 3));
    endtask

    task automatic reset_in_listen();
        int c, d, L;
        c = cyc;
        push(K_TX, c + 1, 0, -1);
        bif.cmd_req = 1'b1;
        goto_cyc(c + 1);
        bif.cmd_req = 1'b0;
        d = c + 5;
        L = d + 1 + T1_MIN;
        push(K_CLR, L, -1, -1);
        push(K_RON, L, -1, -1);
        pulse(d, P_TXDONE);
        goto_cyc(L + 10);
        #2 rst = 1'b1;
        #1;
        check_val("rst_busy", int'(bif.busy), 0);
        check_val("rst_rx_en", int'(bif.rx_en), 0);
        check_val("rst_attempt", int'(bif.attempt), 0);
        check_val("rst_fail_code", int'(bif.fail_code), 0);
        for (int k = 0; k < 7; k++) q[k].delete();
        @(negedge clk);
        #1 rst = 1'b0;
        goto_cyc(cyc + 60);
    endtask

    initial begin
        bif.cmd_req = 1'b0;
        bif.abort   = 1'b0;
        bif.tx_done = 1'b0;
        bif.rx_sof  = 1'b0;
        bif.rx_eof  = 1'b0;
        bif.crc_ok  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_tx_start", int'(bif.tx_start), 0);
        check_val("reset_rx_en", int'(bif.rx_en), 0);
        check_val("reset_rx_clr", int'(bif.rx_clr), 0);
        check_val("reset_reply_ok", int'(bif.reply_ok), 0);
        check_val("reset_reply_fail", int'(bif.reply_fail), 0);
        check_val("reset_fail_code", int'(bif.fail_code), 0);
        check_val("reset_attempt", int'(bif.attempt), 0);
        check_val("reset_busy", int'(bif.busy), 0);
        rst = 1'b0;
        goto_cyc(cyc + 2);

        exchange(O_OK, O_OK, O_OK, 1'b0, 30, 10, 1'b0);
        exchange(O_NOREPLY, O_NOREPLY, O_NOREPLY, 1'b0, -1, -1, 1'b0);
        exchange(O_CRC, O_OK, O_OK, 1'b0, -1, -1, 1'b0);
        exchange(O_NOREPLY, O_OK, O_OK, 1'b0, -1, -1, 1'b1);
        exchange(O_OK, O_OK, O_OK, 1'b0, T1_MAX - 1, RX_MAX - 1, 1'b0);
        exchange(O_CRC, O_CRC, O_CRC, 1'b0, T1_MAX - 1, RX_MAX - 1, 1'b0);
        exchange(O_FRAME, O_FRAME, O_FRAME, 1'b0, -1, -1, 1'b1);
        exchange(O_OK, O_OK, O_OK, 1'b1, -1, -1, 1'b1);
        reset_in_listen();
        repeat (25) begin
            exchange(O_RAND, O_RAND, O_RAND, ($urandom_range(0, 4) == 0), -1, -1,
                     1'($urandom_range(0, 1)));
        end
        goto_cyc(cyc + 5);

        for (int k = 0; k < 7; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                failures++;
                $display("FAIL drain_kind%0d: got %0d pending events, required 0", k, q[k].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
